// File: rtl/i2c_adc_responder.sv
// I2C target emulating a 4-register ADS1115-style ADC on an open-drain bus.
// Pads are synchronised and glitch-filtered. A two-process FSM decodes
// address, pointer, write words and read bytes against four 16-bit registers.

// Two-flop synchroniser followed by a stability counter. The filtered level
// follows the synchronised pad only after FILTER_LEN consecutive cycles of
// disagreement, so shorter pulses never reach the protocol logic.
module i2c_adc_pad_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic sys_clk1,
  input  logic reset,
  input  logic pad_in,
  output logic level
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic       meta_q;
  logic       sync_q;
  logic       filt_q;
  logic       filt_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Synchroniser chain and filter state; idle bus level is high.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      meta_q <= pad_in;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Count cycles of disagreement; flip the filtered level on the last one.
  // NOTE: each _d gets its default before any branch, so no latch can be inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign level = filt_q;

endmodule

module i2c_adc_responder #(
  parameter logic [6:0]  DEV_ADDR   = 7'b1001000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        sys_clk1,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] config_out,
  output logic        config_wr,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_MSB,
    S_MSB_ACK,
    S_WR_LSB,
    S_LSB_ACK,
    S_RD_BYTE,
    S_RD_ACK
  } state_t;

  localparam logic [15:0] CONV_RST = 16'h0000;
  localparam logic [15:0] CFG_RST  = 16'h8583;
  localparam logic [15:0] LO_RST   = 16'h8000;
  localparam logic [15:0] HI_RST   = 16'h7FFF;

  // Conditioned pad levels and their previous values for edge detection.
  logic scl_f;
  logic sda_f;
  logic scl_prev_q;
  logic sda_prev_q;

  i2c_adc_pad_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .sys_clk1 (sys_clk1),
    .reset    (reset),
    .pad_in   (scl_in),
    .level    (scl_f)
  );

  i2c_adc_pad_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .sys_clk1 (sys_clk1),
    .reset    (reset),
    .pad_in   (sda_in),
    .level    (sda_f)
  );

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  =  scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f &  scl_prev_q;
  // sda moving while scl stays high is a bus condition, never a data bit.
  assign start_det = ~sda_f &  sda_prev_q & scl_f & scl_prev_q;
  assign stop_det  =  sda_f & ~sda_prev_q & scl_f & scl_prev_q;

  // Protocol and register state.
  state_t      state_q,  state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,  shift_d;
  logic [7:0]  hold_q,   hold_d;
  logic [15:0] rd_sh_q,  rd_sh_d;
  logic        rw_q,     rw_d;
  logic [1:0]  ptr_q,    ptr_d;
  logic [15:0] conv_q,   conv_d;
  logic [15:0] cfg_q,    cfg_d;
  logic [15:0] lo_q,     lo_d;
  logic [15:0] hi_q,     hi_d;
  logic        busy_q,   busy_d;
  logic        sda_oe_q, sda_oe_d;
  logic        cfg_wr_q, cfg_wr_d;

  logic [7:0]  rx_byte;
  logic        addr_match;
  logic [15:0] sel_reg;
  logic [15:0] snap_val;
  logic [15:0] rd_rot;

  // Byte as it stands once the bit on the current scl rise is shifted in.
  assign rx_byte    = {shift_q[6:0], sda_f};
  assign addr_match = (shift_q[7:1] == DEV_ADDR);
  // Rotating keeps the whole snapshot, so an ACK after the LSB wraps to the MSB.
  assign rd_rot     = {rd_sh_q[14:0], rd_sh_q[15]};
  // A sample arriving in the snapshot cycle is taken directly.
  assign snap_val   = ((ptr_q == 2'b00) && sample_valid) ? sample_data : sel_reg;

  // Register selected by the persistent pointer.
  always_comb begin
    sel_reg = conv_q;
    case (ptr_q)
      2'b00:   sel_reg = conv_q;
      2'b01:   sel_reg = cfg_q;
      2'b10:   sel_reg = lo_q;
      default: sel_reg = hi_q;
    endcase
  end

  // State and register file update.
  // NOTE: the four registers are discrete flops with defined power-on values, not a RAM, so they take reset like any other state.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      rd_sh_q    <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= 2'b00;
      conv_q     <= CONV_RST;
      cfg_q      <= CFG_RST;
      lo_q       <= LO_RST;
      hi_q       <= HI_RST;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      cfg_wr_q   <= 1'b0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      rd_sh_q    <= rd_sh_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      conv_q     <= conv_d;
      cfg_q      <= cfg_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      cfg_wr_q   <= cfg_wr_d;
    end
  end

  // Next-state, bit handling and register writes; sda_oe moves only on scl fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    rd_sh_d   = rd_sh_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    conv_d    = sample_valid ? sample_data : conv_q;
    cfg_d     = cfg_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    busy_d    = busy_q;
    sda_oe_d  = sda_oe_q;
    cfg_wr_d  = 1'b0;

    case (state_q)
      S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB: begin
        if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (state_q == S_PTR) begin
              ptr_d = rx_byte[1:0];
            end
            if (state_q == S_WR_LSB) begin
              case (ptr_q)
                2'b01: begin
                  cfg_d    = {hold_q, rx_byte};
                  cfg_wr_d = 1'b1;
                end
                2'b10:   lo_d = {hold_q, rx_byte};
                2'b11:   hi_d = {hold_q, rx_byte};
                default: ;  // conversion register is read-only
              endcase
            end
          end
        end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
          bit_cnt_d = '0;
          case (state_q)
            S_ADDR: begin
              if (addr_match) begin
                state_d  = S_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
              end
            end
            S_PTR: begin
              state_d  = S_PTR_ACK;
              sda_oe_d = 1'b1;
            end
            S_WR_MSB: begin
              hold_d   = shift_q;
              state_d  = S_MSB_ACK;
              sda_oe_d = 1'b1;
            end
            default: begin
              state_d  = S_LSB_ACK;
              sda_oe_d = 1'b1;
            end
          endcase
        end
      end

      S_ADDR_ACK: begin
        if (scl_fall) begin
          if (rw_q) begin
            state_d  = S_RD_BYTE;
            rd_sh_d  = snap_val;
            sda_oe_d = ~snap_val[15];
          end else begin
            state_d  = S_PTR;
            sda_oe_d = 1'b0;
          end
        end
      end

      S_PTR_ACK: begin
        if (scl_fall) begin
          state_d  = S_WR_MSB;
          sda_oe_d = 1'b0;
        end
      end

      S_MSB_ACK: begin
        if (scl_fall) begin
          state_d  = S_WR_LSB;
          sda_oe_d = 1'b0;
        end
      end

      S_LSB_ACK: begin
        if (scl_fall) begin
          state_d  = S_WR_MSB;
          sda_oe_d = 1'b0;
        end
      end

      S_RD_BYTE: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = S_RD_ACK;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end else begin
            rd_sh_d  = rd_rot;
            sda_oe_d = ~rd_rot[15];
          end
        end
      end

      S_RD_ACK: begin
        if (scl_rise) begin
          shift_d = rx_byte;
        end else if (scl_fall) begin
          if (!shift_q[0]) begin
            state_d  = S_RD_BYTE;
            rd_sh_d  = rd_rot;
            sda_oe_d = ~rd_rot[15];
          end else begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
          end
        end
      end

      default: ;  // S_IDLE waits for START
    endcase

    // Bus conditions override every state; scl is steady high when they occur.
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign config_out = cfg_q;
  assign config_wr  = cfg_wr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Self-checking bench: a bit-banged I2C master on a wired-AND bus, random
// transactions, and a register-level reference model of the ADC target.
module tb_i2c_adc_responder;

  localparam logic [6:0] DEV = 7'b1001000;
  localparam int         Q   = 6;  // sys_clk1 cycles per quarter bit

  logic        clk          = 1'b0;
  logic        rst          = 1'b1;
  logic        scl_m        = 1'b1;
  logic        sda_m        = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data  = 16'h0000;
  logic        sda_oe;
  logic        config_wr;
  logic        busy;
  logic [15:0] config_out;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_adc_responder #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .sys_clk1     (clk),
    .reset        (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .config_out   (config_out),
    .config_wr    (config_wr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Activity counters for the duration checks.
  int oe_cnt   = 0;
  int busy_cnt = 0;
  int wr_cnt   = 0;
  always @(posedge clk) begin
    if (sda_oe)    oe_cnt   <= oe_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (config_wr) wr_cnt   <= wr_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: register contents, pointer, expected config_wr pulses.
  logic [15:0] mdl_reg [4];
  logic [1:0]  mdl_ptr;
  int          exp_wr = 0;

  task automatic mdl_reset();
    mdl_reg[0] = 16'h0000;
    mdl_reg[1] = 16'h8583;
    mdl_reg[2] = 16'h8000;
    mdl_reg[3] = 16'h7FFF;
    mdl_ptr    = 2'b00;
  endtask

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic push_sample(input logic [15:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    mdl_reg[0]   = v;
  endtask

  // One bit: data set with scl low, line sampled mid-high, optional 1-cycle scl glitch.
  task automatic bus_bit(input logic b, input logic glitch, output logic r);
    wait_q(); sda_m = b;
    wait_q(); scl_m = 1'b1;
    wait_q(); r = sda_line;
    if (glitch) begin
      scl_m = 1'b0;
      @(negedge clk);
      scl_m = 1'b1;
    end
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q(2);
  endtask

  task automatic put_byte(input logic [7:0] b, input int glitch_at, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) bus_bit(b[7-i], (i == glitch_at), r);
    bus_bit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic get_byte(input logic nack, input int pulse_at, input logic [15:0] pulse_val,
                          output logic [7:0] b);
    logic r;
    for (int i = 0; i < 8; i++) begin
      if (i == pulse_at) push_sample(pulse_val);
      bus_bit(1'b1, 1'b0, r);
      b[7-i] = r;
    end
    bus_bit(nack, 1'b0, r);
  endtask

  task automatic wr_xfer(input logic [6:0] addr, input logic [7:0] ptr_byte, input int n_words,
                         input logic [15:0] w0, input logic [15:0] w1, input logic half,
                         input int glitch_at);
    logic        ack;
    logic        hit;
    logic [15:0] w;
    int          oe0;
    int          busy0;
    hit   = (addr == DEV);
    oe0   = oe_cnt;
    busy0 = busy_cnt;
    bus_start();
    put_byte({addr, 1'b0}, -1, ack);
    check("addr_ack", 32'(ack), 32'(hit));
    if (hit) begin
      check("busy_on", 32'(busy), 32'd1);
      mdl_ptr = ptr_byte[1:0];
    end
    put_byte(ptr_byte, -1, ack);
    check("ptr_ack", 32'(ack), 32'(hit));
    for (int k = 0; k < n_words; k++) begin
      w = (k == 0) ? w0 : w1;
      put_byte(w[15:8], -1, ack);
      check("msb_ack", 32'(ack), 32'(hit));
      put_byte(w[7:0], (k == n_words - 1) ? glitch_at : -1, ack);
      check("lsb_ack", 32'(ack), 32'(hit));
      if (hit && (mdl_ptr != 2'd0)) begin
        mdl_reg[mdl_ptr] = w;
        if (mdl_ptr == 2'd1) exp_wr++;
      end
    end
    if (half) begin
      put_byte(w0[15:8], -1, ack);
      check("half_ack", 32'(ack), 32'(hit));
    end
    bus_stop();
    check("config_out", 32'(config_out), 32'(mdl_reg[1]));
    check("config_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    check("busy_off", 32'(busy), 32'd0);
    if (!hit) begin
      check("miss_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      check("miss_busy_cycles", 32'(busy_cnt - busy0), 32'd0);
    end
  endtask

  task automatic rd_xfer(input logic set_ptr, input logic [7:0] ptr_byte, input int n_bytes,
                         input int pulse_byte, input logic [15:0] pulse_val);
    logic        ack;
    logic [15:0] snap;
    logic [7:0]  b;
    if (set_ptr) begin
      bus_start();
      put_byte({DEV, 1'b0}, -1, ack);
      check("rd_waddr_ack", 32'(ack), 32'd1);
      put_byte(ptr_byte, -1, ack);
      check("rd_ptr_ack", 32'(ack), 32'd1);
      mdl_ptr = ptr_byte[1:0];
    end
    bus_start();
    put_byte({DEV, 1'b1}, -1, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    snap = mdl_reg[mdl_ptr];
    for (int k = 0; k < n_bytes; k++) begin
      get_byte((k == n_bytes - 1), (k == pulse_byte) ? 3 : -1, pulse_val, b);
      check("rd_byte", 32'(b), (k % 2 == 0) ? 32'(snap[15:8]) : 32'(snap[7:0]));
    end
    wait_q();
    check("nack_release", 32'(sda_oe), 32'd0);
    bus_stop();
    check("rd_busy_off", 32'(busy), 32'd0);
  endtask

  initial begin
    logic ack;
    int   op;
    mdl_reset();
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_config", 32'(config_out), 32'h8583);
    check("rst_config_wr", 32'(config_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Config write, conversion read, wrong address.
    wr_xfer(DEV, 8'h01, 1, 16'hC383, 16'h0000, 1'b0, -1);
    push_sample(16'h1234);
    rd_xfer(1'b1, 8'h00, 2, -1, 16'h0000);
    wr_xfer(7'b1001001, 8'h01, 1, 16'hFFFF, 16'h0000, 1'b0, -1);

    // Snapshot integrity: new sample mid-MSB must not disturb the read.
    rd_xfer(1'b0, 8'h00, 2, 0, 16'hABCD);
    rd_xfer(1'b0, 8'h00, 2, -1, 16'h0000);

    // Partial write, then a 1-cycle scl glitch inside a data byte.
    wr_xfer(DEV, 8'h01, 0, 16'h0000, 16'h0000, 1'b1, -1);
    wr_xfer(DEV, 8'h01, 1, 16'h5A3C, 16'h0000, 1'b0, 3);

    // Reset mid-read while the target is pulling sda low.
    wr_xfer(DEV, 8'h03, 1, 16'h1234, 16'h0000, 1'b0, -1);
    bus_start();
    put_byte({DEV, 1'b1}, -1, ack);
    check("pre_rst_ack", 32'(ack), 32'd1);
    wait_q();
    check("rd_drive", 32'(sda_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_config", 32'(config_out), 32'h8583);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(2);
    rd_xfer(1'b1, 8'h01, 2, -1, 16'h0000);

    // Randomised traffic against the model.
    for (int it = 0; it < 18; it++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        logic [6:0] a;
        a = ($urandom_range(0, 4) == 0) ? (DEV ^ 7'($urandom_range(1, 127))) : DEV;
        wr_xfer(a, {6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 1'b0, -1);
      end else if (op == 1) begin
        rd_xfer(1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                int'($urandom_range(1, 4)), -1, 16'h0000);
      end else begin
        push_sample(16'($urandom));
        repeat (4) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_adc_responder.md
# i2c_adc_responder

Synthesizable I2C target that emulates the 4-register ADS1115-style ADC at address 7'b1001000, so the existing I2C master and ADC controller can be exercised without the physical converter. It sits on the same open-drain scl/sda pair as the master. It serves conversion data supplied by an internal sample source, and it exposes the config register the master writes. The top level wires the pads as: sda = sda_oe ? 1'b0 : 1'bz, with scl and sda read back as inputs.

## Interface
- DEV_ADDR, 7'b1001000, 7-bit target address
- FILTER_LEN, 3, consecutive stable sys_clk1 cycles required before a filtered scl/sda level changes (1..15)
- sys_clk1  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- scl_in  in  1  raw scl pad level (asynchronous)
- sda_in  in  1  raw sda pad level (asynchronous)
- sda_oe  out  1  1 = pull sda low; 0 = release
- sample_data  in  16  new conversion value, two's complement
- sample_valid  in  1  one-cycle strobe; loads sample_data into the conversion register
- config_out  out  16  current config register
- config_wr  out  1  one-cycle pulse when config_out takes a new master-written value
- busy  out  1  high from an address-matched START until STOP, or until a mismatch returns the block to IDLE

## Operation
- Input conditioning: each pad passes through a 2-flop synchronizer, then a counter filter of FILTER_LEN cycles. Edges are detected on the filtered levels.
- START: filtered sda falls while filtered scl is high. STOP: filtered sda rises while filtered scl is high. Both are recognised in every state. A START inside a transaction is a repeated START and goes to ADDR.
- Bit handling: sda is sampled on the filtered scl rising edge. sda_oe changes only on the filtered scl falling edge, so data is never changed while scl is high.
- Registers, indexed by pointer[1:0]:
  - 00: conversion, read-only, reset 16'h0000
  - 01: config, reset 16'h8583
  - 10: lo_thresh, reset 16'h8000
  - 11: hi_thresh, reset 16'h7FFF
  - The pointer resets to 00 and persists across transactions.
- States:
  - IDLE
  - ADDR: 8 bits received, MSB first.
  - ADDR_ACK:
    - Address matches DEV_ADDR: drive ACK, set busy, then go to PTR if R/W=0 or RD_BYTE if R/W=1.
    - Address mismatch: no ACK; go to IDLE and ignore everything until the next START.
  - PTR: 8 bits received; bits[1:0] load the pointer and bits[7:2] are ignored. ACK, then WR_MSB.
  - WR_MSB: 8 bits received into a holding register. ACK, then WR_LSB.
  - WR_LSB: 8 bits received.
    - On the 8th bit, commit {hold, byte} to the pointed register. A write to pointer 00 is discarded.
    - A commit to 01 pulses config_wr.
    - ACK, then WR_MSB for a further word.
  - RD_BYTE: on entry from ADDR_ACK, snapshot the pointed register into a 16-bit shift register. Shift out the MSB byte, then the LSB byte.
  - RD_ACK: sample the master's bit.
    - ACK (0): continue with the next byte. After the LSB, wrap to the MSB of the same snapshot.
    - NACK (1): release sda and wait for STOP or START.
- STOP after WR_MSB without a completed LSB discards the held byte.
- If sample_valid coincides with the snapshot cycle, the snapshot takes the new sample_data (bypass).
- A sample_valid during a read never alters bytes already snapshotted.

## Timing
- Values after reset: sda_oe=0, config_out=16'h8583, config_wr=0, busy=0, pointer=00, state IDLE.
- Pad-to-internal-edge latency is 2+FILTER_LEN cycles. Pulses shorter than FILTER_LEN cycles are ignored.
- ACK drive:
  - sda_oe rises 1 cycle after the filtered scl falling edge that ends bit 8.
  - sda_oe falls 1 cycle after the filtered scl falling edge that ends bit 9.
- Read data: sda_oe = ~bit, updated 1 cycle after each filtered scl falling edge.
- config_wr is asserted the cycle after the 8th filtered scl rising edge of WR_LSB. config_out updates in the same cycle.
- When STOP or START is detected, sda_oe drops to 0 in the following cycle.

## Test plan
- Config write: START, 0x90, 0x01, 0xC3, 0x83, STOP.
  - Required: four ACKs, exactly one config_wr pulse, config_out=16'hC383, busy low after STOP.
- Conversion read: sample_valid with 0x1234. Then START, 0x90, 0x00, repeated START, 0x91, read two bytes (ACK, then NACK), STOP.
  - Required: bytes 0x12 and 0x34, sda_oe=0 after the NACK.
- Wrong address: START, 0x92, 0x01, 0xFF, 0xFF, STOP.
  - Required: sda_oe=0 throughout, busy=0, config_out unchanged, no config_wr pulse.
- Snapshot integrity: read started with conversion=0x1234; sample_valid with 0xABCD during the MSB.
  - Required: the read returns 0x1234; the next read returns 0xABCD.
- Partial write and glitch:
  - STOP after 0x90, 0x01, 0x00. Required: config_out unchanged, no config_wr pulse.
  - A 1-cycle scl low pulse with FILTER_LEN=3. Required: no bit counted.
- Reset mid-read while sda_oe=1.
  - Required: sda_oe=0 asynchronously, config_out=16'h8583, busy=0, and the next transaction decodes normally.
